// File: rtl/aurora_hls_nfc_pkg.sv
// aurora_hls_nfc_pkg: NFC controller state encoding, message codes and saturating-count helper
package aurora_hls_nfc_pkg;
    typedef enum logic [2:0] {ST_RESET, ST_FLOW_ON, ST_SEND_XOFF, ST_PAUSED, ST_SEND_XON} nfc_state_e;
    typedef enum logic [1:0] {MSG_XOFF, MSG_XON, MSG_REFRESH} nfc_msg_e;
    localparam logic [15:0] NFC_XOFF = 16'hFFFF;
    localparam logic [15:0] NFC_XON  = 16'h0000;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/aurora_hls_nfc_msg_tx.sv
// aurora_hls_nfc_msg_tx: valid/ready holding register for one NFC message
//   clk, rst_n   : clock, synchronous active-low reset
//   load_i       : start a message of type kind_i (only asserted while idle)
//   tready_i     : channel ready
//   tvalid_o     : message valid, held until accepted
//   tdata_o      : message word, frozen while tvalid_o is high
//   done_o       : handshake pulse, done_kind_o tells which message was accepted
module aurora_hls_nfc_msg_tx
    import aurora_hls_nfc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  nfc_msg_e    kind_i,
    input  logic        tready_i,
    output logic        tvalid_o,
    output logic [0:15] tdata_o,
    output logic        done_o,
    output nfc_msg_e    done_kind_o
);
    logic        valid_q, valid_d;
    logic [0:15] data_q, data_d;
    nfc_msg_e    kind_q, kind_d;

    assign done_o = valid_q & tready_i;

    always_comb begin
        valid_d = load_i ? 1'b1 : (done_o ? 1'b0 : valid_q);
        data_d  = load_i ? ((kind_i == MSG_XON) ? NFC_XON : NFC_XOFF) : data_q;
        kind_d  = load_i ? kind_i : kind_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= NFC_XON;
            kind_q  <= MSG_XOFF;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            kind_q  <= kind_d;
        end
    end

    assign tvalid_o    = valid_q;
    assign tdata_o     = data_q;
    assign done_kind_o = kind_q;
endmodule

// File: rtl/aurora_hls_nfc_thresh.sv
// aurora_hls_nfc_thresh: RX FIFO fill hysteresis controller issuing Aurora NFC XOFF/XON messages
//   clk, rst_n              : clock, synchronous active-low reset
//   fifo_rx_fill            : RX FIFO occupancy in words (unsigned, FILL_W bits)
//   xoff_th / xon_th        : pause at fill >= xoff_th, resume at fill <= xon_th
//   s_axi_nfc_t*            : NFC message channel (16'hFFFF = XOFF, 16'h0000 = XON)
//   cfg_err                 : xon_th >= xoff_th; no new message starts while high
//   xoff/xon/refresh_count  : saturating counts of accepted messages per type
//   NFC_REFRESH_EN          : define to resend XOFF every REFRESH_CYCLES cycles while paused
module aurora_hls_nfc_thresh
    import aurora_hls_nfc_pkg::*;
#(
    parameter int FILL_W         = 12,
    parameter int REFRESH_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FILL_W-1:0] fifo_rx_fill,
    input  logic [FILL_W-1:0] xoff_th,
    input  logic [FILL_W-1:0] xon_th,
    input  logic              s_axi_nfc_tready,
    output logic              s_axi_nfc_tvalid,
    output logic [0:15]       s_axi_nfc_tdata,
    output logic              cfg_err,
    output logic [31:0]       xoff_count,
    output logic [31:0]       xon_count,
    output logic [31:0]       refresh_count
);
    if (REFRESH_CYCLES < 2 || REFRESH_CYCLES > 2**24) begin : g_bad_refresh
        $error("REFRESH_CYCLES out of range 2..2^24");
    end

    nfc_state_e  state_q, state_d;
    nfc_msg_e    kind, done_kind;
    logic        load, done, xoff_hit, xon_hit;
    logic [31:0] xoff_cnt_q, xon_cnt_q;

    assign cfg_err  = xon_th >= xoff_th;
    assign xoff_hit = !cfg_err && fifo_rx_fill >= xoff_th;
    assign xon_hit  = !cfg_err && fifo_rx_fill <= xon_th;

`ifdef NFC_REFRESH_EN
    localparam int TW = $clog2(REFRESH_CYCLES);
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   refresh_cnt_q;
    logic          refresh_due;
    assign refresh_due = timer_q == TW'(REFRESH_CYCLES - 1);
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        kind    = MSG_XOFF;
`ifdef NFC_REFRESH_EN
        timer_d = '0;
`endif
        case (state_q)
            ST_RESET, ST_FLOW_ON: begin
                state_d = xoff_hit ? ST_SEND_XOFF : ST_FLOW_ON;
                load    = xoff_hit;
            end
            ST_SEND_XOFF: state_d = done ? ST_PAUSED : ST_SEND_XOFF;
            ST_SEND_XON:  state_d = done ? ST_FLOW_ON : ST_SEND_XON;
            ST_PAUSED: begin
                if (xon_hit) begin
                    state_d = ST_SEND_XON;
                    load    = 1'b1;
                    kind    = MSG_XON;
                end
`ifdef NFC_REFRESH_EN
                else if (refresh_due && !cfg_err) begin
                    state_d = ST_SEND_XOFF;
                    load    = 1'b1;
                    kind    = MSG_REFRESH;
                end else
                    // a blocked refresh stays due until cfg_err clears
                    timer_d = refresh_due ? timer_q : timer_q + 1'b1;
`endif
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            xoff_cnt_q <= '0;
            xon_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            xoff_cnt_q <= sat_inc(xoff_cnt_q, done && done_kind == MSG_XOFF);
            xon_cnt_q  <= sat_inc(xon_cnt_q, done && done_kind == MSG_XON);
        end
    end

`ifdef NFC_REFRESH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q       <= '0;
            refresh_cnt_q <= '0;
        end else begin
            timer_q       <= timer_d;
            refresh_cnt_q <= sat_inc(refresh_cnt_q, done && done_kind == MSG_REFRESH);
        end
    end
    assign refresh_count = refresh_cnt_q;
`else
    assign refresh_count = '0;
`endif

    assign xoff_count = xoff_cnt_q;
    assign xon_count  = xon_cnt_q;

    aurora_hls_nfc_msg_tx u_msg_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .kind_i     (kind),
        .tready_i   (s_axi_nfc_tready),
        .tvalid_o   (s_axi_nfc_tvalid),
        .tdata_o    (s_axi_nfc_tdata),
        .done_o     (done),
        .done_kind_o(done_kind)
    );
endmodule

// File: tb/tb_aurora_hls_nfc_thresh.sv
// tb_aurora_hls_nfc_thresh: scoreboard bench for the NFC threshold controller
module tb_aurora_hls_nfc_thresh;
    localparam int W  = 12;
    localparam int RC = 16;
`ifdef NFC_REFRESH_EN
    localparam bit REF = 1'b1;
`else
    localparam bit REF = 1'b0;
`endif

    logic          clk = 0, rst_n = 0, tready = 0;
    logic [W-1:0]  fill = 0, xoff_th = 100, xon_th = 20;
    logic          tvalid, cfg_err;
    logic [0:15]   tdata;
    logic [31:0]   xoff_count, xon_count, refresh_count;
    int            checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;

    aurora_hls_nfc_thresh #(.FILL_W(W), .REFRESH_CYCLES(RC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_rx_fill    (fill),
        .xoff_th         (xoff_th),
        .xon_th          (xon_th),
        .s_axi_nfc_tready(tready),
        .s_axi_nfc_tvalid(tvalid),
        .s_axi_nfc_tdata (tdata),
        .cfg_err         (cfg_err),
        .xoff_count      (xoff_count),
        .xon_count       (xon_count),
        .refresh_count   (refresh_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: link is either paused or flowing; at most one message outstanding.
    typedef struct {
        bit          init, paused, busy;
        logic [15:0] data;
        int          kind, timer;
        logic [31:0] cx, cn, cr;
    } model_t;
    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;

    model_t m, mn;
    exp_t   q[$];

    function automatic model_t step(model_t s, bit rn, int f, int hi, int lo, bit rdy);
        model_t r = s;
        bit bad = lo >= hi;
        if (!rn) begin
            r.init = 1; r.paused = 0; r.busy = 0; r.timer = 0; r.kind = 0;
            r.data = 16'h0000; r.cx = 0; r.cn = 0; r.cr = 0;
            return r;
        end
        if (s.busy) begin
            if (rdy) begin
                r.busy = 0;
                r.timer = 0;
                if (s.kind == 0) r.cx = s.cx + 1;
                else if (s.kind == 1) r.cn = s.cn + 1;
                else r.cr = s.cr + 1;
            end
            return r;
        end
        r.init = 0;
        if (s.init || !s.paused) begin
            if (f >= hi && !bad) begin r.busy = 1; r.paused = 1; r.kind = 0; r.data = 16'hFFFF; end
        end else if (f <= lo && !bad) begin
            r.busy = 1; r.paused = 0; r.kind = 1; r.data = 16'h0000;
        end else if (REF) begin
            if (s.timer == RC - 1) begin
                if (!bad) begin r.busy = 1; r.kind = 2; r.data = 16'hFFFF; end
            end else r.timer = s.timer + 1;
        end
        return r;
    endfunction

    always_comb mn = step(m, rst_n, int'(fill), int'(xoff_th), int'(xon_th), tready);

    always @(posedge clk) begin
        m   <= mn;
        cyc <= cyc + 1;
        if (mn.busy && !m.busy) q.push_back('{mn.data, cyc + 1});
    end

    // Monitor: compares every cycle away from the clock edge, pops the scoreboard on each new message.
    logic        pv = 0, pr = 0;
    logic [0:15] pd = 0;
    always @(negedge clk) begin
        chk("tvalid", tvalid, m.busy);
        chk("cfg_err", cfg_err, xon_th >= xoff_th);
        chk("xoff_count", xoff_count, m.cx);
        chk("xon_count", xon_count, m.cn);
        chk("refresh_count", refresh_count, m.cr);
        if (tvalid && !pv) begin
            if (q.size() == 0) chk("unexpected_msg", 1, 0);
            else begin
                chk("msg_data", tdata, q[0].data);
                chk("msg_start_cycle", cyc, q[0].at);
                void'(q.pop_front());
            end
        end
        if (tvalid && pv && !pr) chk("hold_tdata", tdata, pd);
        pv <= tvalid;
        pr <= tready;
        pd <= tdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen, sel;
        logic [W-1:0] near;
        tready = 1;
        tick(3);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 16'h0000);
        chk("rst_xoff_count", xoff_count, 0);
        rst_n = 1;
        tick(3);
        fill = 99;
        tick(3);
        chk("below_xoff_idle", tvalid, 0);
        fill = 100;
        tick(1);
        chk("xoff_tvalid", tvalid, 1);
        chk("xoff_tdata", tdata, 16'hFFFF);
        tick(1);
        chk("xoff_done", tvalid, 0);
        chk("xoff_count_1", xoff_count, 1);
        fill = 50;
        tick(3);
        chk("hysteresis_idle", tvalid, 0);
        tready = 0;
        fill = 20;
        tick(1);
        chk("xon_tvalid", tvalid, 1);
        chk("xon_tdata", tdata, 16'h0000);
        tick(5);
        chk("xon_held_tvalid", tvalid, 1);
        chk("xon_held_tdata", tdata, 16'h0000);
        chk("xon_count_0", xon_count, 0);
        tready = 1;
        tick(1);
        chk("xon_done", tvalid, 0);
        chk("xon_count_1", xon_count, 1);
        fill = 200;
        tick(80);
        chk("xoff_count_2", xoff_count, 2);
`ifdef NFC_REFRESH_EN
        chk("refresh_nonzero", refresh_count != 0, 1);
`else
        chk("refresh_zero", refresh_count, 0);
`endif
        for (int n = 0; n < 40 && tvalid; n++) tick(1);
        chk("idle_before_sweep", tvalid, 0);
        xon_th = 50;
        xoff_th = 50;
        tick(1);
        chk("cfg_err_high", cfg_err, 1);
        seen = 0;
        for (int i = 0; i < 4096; i++) begin
            fill = W'(i);
            tick(1);
            seen += int'(tvalid);
        end
        chk("cfg_err_no_tvalid", seen, 0);
        for (int b = 0; b < 30; b++) begin
            xoff_th = W'($urandom_range(1, 4095));
            xon_th = ($urandom_range(0, 7) == 0) ? W'($urandom_range(int'(xoff_th), 4095))
                                                 : W'($urandom_range(0, int'(xoff_th) - 1));
            for (int i = 0; i < 60; i++) begin
                sel = $urandom_range(0, 3);
                near = (sel == 1) ? xoff_th : xon_th;
                fill = (sel == 0) ? W'($urandom_range(0, 4095)) : near + W'($urandom_range(0, 4)) - W'(2);
                tready = $urandom_range(0, 3) != 0;
                tick(1);
            end
        end
        xoff_th = 100;
        xon_th = 20;
        fill = 0;
        tready = 1;
        tick(40);
        fill = 300;
        tready = 0;
        tick(2);
        chk("pre_reset_tvalid", tvalid, 1);
        rst_n = 0;
        tick(1);
        chk("reset_drop_tvalid", tvalid, 0);
        chk("reset_xoff_count", xoff_count, 0);
        chk("reset_xon_count", xon_count, 0);
        tick(1);
        rst_n = 1;
        tick(1);
        chk("post_reset_xoff", tvalid, 1);
        chk("post_reset_tdata", tdata, 16'hFFFF);
        tready = 1;
        tick(1);
        chk("post_reset_count", xoff_count, 1);
        tick(5);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
